// File: rtl/uart_tx_arbiter_pkg.sv
// Shared constants for the UART transmit arbiter: FSM encodings, byte width,
// default sizing and an index-width helper.
package uart_arb_pkg;
  localparam int BYTE_W          = 8;
  localparam int NUM_REQ_DEF     = 2;
  localparam int TIMEOUT_CYC_DEF = 100000;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  // Never returns less than 1 so a 1-bit index exists even for tiny vectors.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Frame-source and uart_tx_path handshake bundle for uart_tx_arbiter.
interface uart_tx_arbiter_if import uart_arb_pkg::*; #(
  parameter int NUM_REQ = NUM_REQ_DEF
) ();
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0][BYTE_W-1:0] req_data;
  logic [NUM_REQ-1:0]             req_last;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ-1:0]             grant;
  logic [BYTE_W-1:0]              uart_tx_data;
  logic                           uart_tx_en;
  logic                           uart_tx_done;

  modport slave (
    input  req_valid, req_data, req_last, uart_tx_done,
    output req_ready, grant, uart_tx_data, uart_tx_en
  );

  modport master (
    output req_valid, req_data, req_last, uart_tx_done,
    input  req_ready, grant, uart_tx_data, uart_tx_en
  );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid bit at or after ptr, wrapping.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);
  logic [IW:0]   s;
  logic [IW-1:0] j;

  // Walk offsets from farthest to nearest so the nearest valid wins.
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = |valid;
    s      = '0;
    j      = '0;
    for (int k = N - 1; k >= 0; k--) begin
      s = {1'b0, ptr} + (IW+1)'(k);
      if (s >= (IW+1)'(N)) s = s - (IW+1)'(N);
      j = s[IW-1:0];
      if (valid[j]) begin
        onehot    = '0;
        onehot[j] = 1'b1;
        idx       = j;
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Frame-atomic round-robin arbiter in front of uart_tx_path.
// Define UART_TX_TIMEOUT_EN to abort a byte whose uart_tx_done never arrives.
module uart_tx_arbiter import uart_arb_pkg::*; #(
  parameter int NUM_REQ     = NUM_REQ_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_tx_arbiter_if.slave bus,
  output logic             busy,
  output logic             err_timeout
);
  localparam int IW = clog2(NUM_REQ);

  logic [1:0]         state;
  logic [IW-1:0]      gidx, ptr, ptr_nxt, pick_idx;
  logic [NUM_REQ-1:0] pick_oh;
  logic               pick_any, last_q, to_hit;

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .valid (bus.req_valid),
    .ptr   (ptr),
    .onehot(pick_oh),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // ptr holds the first source to consider, i.e. last_granted+1.
  assign ptr_nxt = (gidx == IW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
  assign busy    = (state != ST_IDLE);

`ifdef UART_TX_TIMEOUT_EN
  logic [31:0] to_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 to_cnt <= '0;
    else if (state == ST_LOAD)  to_cnt <= '0;
    else if (state == ST_WAIT)  to_cnt <= to_cnt + 32'd1;
  end

  assign to_hit = (state == ST_WAIT) && (to_cnt == 32'(TIMEOUT_CYC - 1));
`else
  logic [31:0] unused_timeout_cyc;
  assign unused_timeout_cyc = 32'(TIMEOUT_CYC);
  assign to_hit             = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      gidx             <= '0;
      ptr              <= '0;
      last_q           <= 1'b0;
      bus.grant        <= '0;
      bus.req_ready    <= '0;
      bus.uart_tx_data <= '0;
      bus.uart_tx_en   <= 1'b0;
      err_timeout      <= 1'b0;
    end else begin
      bus.uart_tx_en <= 1'b0;
      bus.req_ready  <= '0;
      err_timeout    <= 1'b0;
      case (state)
        ST_IDLE: if (pick_any) begin
          bus.grant <= pick_oh;
          gidx      <= pick_idx;
          state     <= ST_LOAD;
        end
        ST_LOAD: if (bus.req_valid[gidx]) begin
          bus.uart_tx_data    <= bus.req_data[gidx];
          bus.uart_tx_en      <= 1'b1;
          bus.req_ready[gidx] <= 1'b1;
          last_q              <= bus.req_last[gidx];
          state               <= ST_WAIT;
        end
        ST_WAIT: begin
          // A done coinciding with the timeout completes the byte normally.
          if (bus.uart_tx_done) begin
            if (last_q) begin
              bus.grant <= '0;
              ptr       <= ptr_nxt;
              state     <= ST_IDLE;
            end else begin
              state     <= ST_LOAD;
            end
          end else if (to_hit) begin
            err_timeout <= 1'b1;
            bus.grant   <= '0;
            ptr         <= ptr_nxt;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter; timeout scenarios run when
// UART_TX_TIMEOUT_EN is defined.
module tb_uart_tx_arbiter;
  import uart_arb_pkg::*;

  localparam int NR = 2;
  localparam int TO = 50;

  typedef struct packed { logic [7:0] d; logic l; } src_t;
  typedef struct packed { logic [7:0] s; logic [7:0] d; } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, err_timeout;
  logic resp_done = 1'b0;
  logic stray_done = 1'b0;

  uart_tx_arbiter_if #(.NUM_REQ(NR)) bus ();

  uart_tx_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYC(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .busy       (busy),
    .err_timeout(err_timeout)
  );

  assign bus.uart_tx_done = resp_done | stray_done;

  always #5 clk = ~clk;

  src_t src_q[NR][$];
  exp_t exp_q[$];
  exp_t e;
  int   nvec = 0, nmis = 0;
  int   cyc = 0, en_cnt = 0, err_cnt = 0, en_cyc = 0;
  int   rdy_cnt[NR];
  int   dly = 10;
  bit   withhold = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic put(input int s, input logic [7:0] d, input logic l);
    src_q[s].push_back(src_t'{d, l});
  endtask

  task automatic sb_push(input int s, input logic [7:0] d);
    exp_q.push_back(exp_t'{8'(s), d});
  endtask

  task automatic wait_exp(input string tag, input int n);
    int t;
    t = 0;
    while (exp_q.size() > n && t < 2000) begin @(negedge clk); t++; end
    chk(tag, 32'(t >= 2000), 32'd0);
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    do begin @(negedge clk); t++; end
    while ((exp_q.size() != 0 || busy) && t < 2000);
    chk(tag, 32'(t >= 2000), 32'd0);
  endtask

  task automatic wait_done(input string tag);
    int t;
    t = 0;
    do begin @(posedge clk); t++; end
    while (!bus.uart_tx_done && t < 200);
    chk(tag, 32'(t >= 200), 32'd0);
  endtask

  task automatic stray_pulse();
    @(negedge clk); #1 stray_done = 1'b1;
    @(negedge clk); #1 stray_done = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk); #1 rst_n = 1'b0;
    for (int i = 0; i < NR; i++) src_q[i].delete();
    exp_q.delete();
    @(negedge clk);
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_en",    32'(bus.uart_tx_en), 32'd0);
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_data",  32'(bus.uart_tx_data), 32'd0);
    chk("rst_err",   32'(err_timeout), 32'd0);
    @(negedge clk); #1 rst_n = 1'b1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Source model: presents the head of each queue until the DUT accepts it.
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < NR; i++) begin
      if (bus.req_valid[i] === 1'b1 && bus.req_ready[i] && src_q[i].size() > 0)
        void'(src_q[i].pop_front());
      if (src_q[i].size() > 0) begin
        bus.req_valid[i] = 1'b1;
        bus.req_data[i]  = src_q[i][0].d;
        bus.req_last[i]  = src_q[i][0].l;
      end else begin
        bus.req_valid[i] = 1'b0;
        bus.req_data[i]  = 8'h00;
        bus.req_last[i]  = 1'b0;
      end
    end
  end

  // uart_tx_path model: done dly cycles after each en, cancelled by reset.
  initial forever begin
    @(negedge clk);
    if (rst_n && bus.uart_tx_en && !withhold) begin
      for (int k = 0; k < dly; k++) begin
        @(negedge clk);
        if (!rst_n) break;
      end
      if (rst_n) begin
        resp_done = 1'b1;
        @(negedge clk);
        resp_done = 1'b0;
      end
    end
  end

  // Output monitor / scoreboard.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      for (int i = 0; i < NR; i++) if (bus.req_ready[i]) rdy_cnt[i]++;
      if (bus.uart_tx_en) begin
        en_cnt++;
        en_cyc = cyc;
        if (exp_q.size() == 0) chk("extra_en", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("data",  32'(bus.uart_tx_data), 32'(e.d));
          chk("grant", 32'(bus.grant), 32'd1 << e.s);
          chk("ready", 32'(bus.req_ready), 32'(bus.grant));
        end
      end else if (bus.req_ready != '0) begin
        chk("ready_no_en", 32'(bus.req_ready), 32'd0);
      end
      if (err_timeout) begin
        err_cnt++;
        chk("err_lat",   32'(cyc - en_cyc), 32'(TO));
        chk("err_grant", 32'(bus.grant), 32'd0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog nvec=%0d nmis=%0d", nvec, nmis);
    $fatal(1);
  end

  initial begin
    int c0, t, n0, r0, e0;
    for (int i = 0; i < NR; i++) rdy_cnt[i] = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_en",    32'(bus.uart_tx_en), 32'd0);
    chk("rst_data",  32'(bus.uart_tx_data), 32'd0);
    chk("rst_err",   32'(err_timeout), 32'd0);
    #1 rst_n = 1'b1;

    // Single source, three-byte frame; first-byte latency and end-of-frame.
    @(negedge clk); #1;
    n0 = en_cnt; r0 = rdy_cnt[0];
    put(0, 8'h41, 1'b0); put(0, 8'h42, 1'b0); put(0, 8'h43, 1'b1);
    sb_push(0, 8'h41); sb_push(0, 8'h42); sb_push(0, 8'h43);
    @(negedge clk); c0 = cyc; t = 0;
    do begin @(negedge clk); t++; end while (!bus.uart_tx_en && t < 50);
    chk("lat_first_en", 32'(cyc - c0), 32'd2);
    wait_exp("t1_drain", 0);
    wait_done("t1_done");
    @(negedge clk);
    chk("t1_busy_low",  32'(busy), 32'd0);
    chk("t1_grant_clr", 32'(bus.grant), 32'd0);
    chk("t1_en_cnt",    32'(en_cnt - n0), 32'd3);
    chk("t1_rdy_cnt",   32'(rdy_cnt[0] - r0), 32'd3);

    // Fresh reset, both sources busy: frames alternate 0,1,0,1.
    pulse_reset();
    @(negedge clk); #1;
    for (int f = 0; f < 2; f++) begin
      put(0, 8'h10, 1'b0); put(0, 8'h11, 1'b1);
      put(1, 8'h20, 1'b0); put(1, 8'h21, 1'b1);
    end
    for (int f = 0; f < 2; f++) begin
      sb_push(0, 8'h10); sb_push(0, 8'h11);
      sb_push(1, 8'h20); sb_push(1, 8'h21);
    end
    wait_idle("t2_idle");

    // Source 1 stalls mid-frame; source 0 must wait for its last byte.
    @(negedge clk); #1;
    put(1, 8'h30, 1'b0); sb_push(1, 8'h30);
    wait_exp("t3_first", 0);
    #1;
    sb_push(1, 8'h31); sb_push(1, 8'h32); sb_push(0, 8'h50);
    put(0, 8'h50, 1'b1);
    n0 = en_cnt;
    repeat (15) begin
      @(negedge clk);
      chk("t3_grant_held", 32'(bus.grant), 32'd2);
    end
    chk("t3_stall_no_en", 32'(en_cnt - n0), 32'd0);
    #1;
    put(1, 8'h31, 1'b0); put(1, 8'h32, 1'b1);
    wait_idle("t3_idle");

    // Stray done in IDLE, then in a stalled LOAD.
    n0 = en_cnt;
    stray_pulse();
    repeat (3) @(negedge clk);
    chk("t4_idle_busy", 32'(busy), 32'd0);
    chk("t4_idle_en",   32'(en_cnt - n0), 32'd0);
    #1;
    put(0, 8'h60, 1'b0); sb_push(0, 8'h60);
    wait_exp("t4_first", 0);
    wait_done("t4_done");
    n0 = en_cnt;
    stray_pulse();
    repeat (4) @(negedge clk);
    chk("t4_load_busy",  32'(busy), 32'd1);
    chk("t4_load_grant", 32'(bus.grant), 32'd1);
    chk("t4_load_en",    32'(en_cnt - n0), 32'd0);
    #1;
    put(0, 8'h61, 1'b1); sb_push(0, 8'h61);
    wait_idle("t4_idle");

    // Reset while byte 2 of a 4-byte frame is in flight.
    @(negedge clk); #1;
    put(0, 8'h70, 1'b0); put(0, 8'h71, 1'b0); put(0, 8'h72, 1'b0); put(0, 8'h73, 1'b1);
    sb_push(0, 8'h70); sb_push(0, 8'h71); sb_push(0, 8'h72); sb_push(0, 8'h73);
    wait_exp("t5_two_sent", 2);
    pulse_reset();
    @(negedge clk); #1;
    put(1, 8'h80, 1'b1); sb_push(1, 8'h80);
    wait_idle("t5_idle");

`ifdef UART_TX_TIMEOUT_EN
    // Withheld done aborts the frame; the other source is served next.
    @(negedge clk); #1;
    withhold = 1'b1;
    e0 = err_cnt;
    put(0, 8'h90, 1'b0); put(0, 8'h91, 1'b1); sb_push(0, 8'h90);
    wait_exp("t6_first", 0);
    #1;
    put(1, 8'hA0, 1'b1); sb_push(1, 8'hA0);
    t = 0;
    while (err_cnt == e0 && t < 200) begin @(negedge clk); t++; end
    chk("t6_err_seen", 32'(err_cnt - e0), 32'd1);
    #1;
    withhold = 1'b0;
    src_q[0].delete();
    wait_idle("t6_idle");

    // Done on the exact timeout cycle completes normally.
    @(negedge clk); #1;
    dly = TO - 1;
    e0 = err_cnt;
    put(0, 8'hB0, 1'b1); sb_push(0, 8'hB0);
    wait_idle("t6b_idle");
    chk("t6b_no_err", 32'(err_cnt - e0), 32'd0);
    dly = 10;
`else
    chk("no_err_pulses", 32'(err_cnt), 32'd0);
`endif

    repeat (3) @(negedge clk);
    chk("end_sb_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
